// File: rtl/ita_package.sv
// Shared types and helpers for the ITA tile sequencer: FSM state encoding,
// tile-count arithmetic and the beats-per-tile constant.
package ita_package;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Number of N-lane beats needed to cover one M x M tile.
    function automatic int unsigned beat_count(input int unsigned m, input int unsigned n);
        return (m * m) / n;
    endfunction

    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/ita_tile_counter.sv
// Beat counter plus the inner -> x -> y tile loop nest; advances one beat per i_en.
module ita_tile_counter
    import ita_package::*;
#(
    parameter int unsigned BEATS = 8,
    parameter int unsigned DIM_W = 12
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       i_clear,
    input  logic                       i_en,
    input  logic [DIM_W:0]             i_tiles_i,
    input  logic [DIM_W:0]             i_tiles_x,
    input  logic [DIM_W:0]             i_tiles_y,
    output logic [$clog2(BEATS)-1:0]   o_count,
    output logic [DIM_W-1:0]           o_inner,
    output logic [DIM_W-1:0]           o_x,
    output logic [DIM_W-1:0]           o_y,
    output logic                       o_first_inner,
    output logic                       o_last_inner,
    output logic                       o_nest_wrap
);
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam int unsigned XW    = DIM_W + 1;

    logic [CNT_W-1:0] r_count;
    logic [DIM_W-1:0] r_inner, r_x, r_y;
    logic w_cnt_last, w_inner_last, w_x_last, w_y_last;
    logic w_count_wrap, w_inner_wrap, w_x_wrap;

    // Index compares are done one bit wider so tiles-1 never underflows.
    assign w_cnt_last   = (r_count == CNT_W'(BEATS - 1));
    assign w_inner_last = ((XW'(r_inner) + XW'(1)) == i_tiles_i);
    assign w_x_last     = ((XW'(r_x) + XW'(1)) == i_tiles_x);
    assign w_y_last     = ((XW'(r_y) + XW'(1)) == i_tiles_y);

    assign w_count_wrap = i_en & w_cnt_last;
    assign w_inner_wrap = w_count_wrap & w_inner_last;
    assign w_x_wrap     = w_inner_wrap & w_x_last;
    assign o_nest_wrap  = w_x_wrap & w_y_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
            r_inner <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_inner <= '0;
            r_x     <= '0;
            r_y     <= '0;
        end else if (i_en) begin
            r_count <= w_cnt_last ? '0 : r_count + CNT_W'(1);
            if (w_count_wrap) r_inner <= w_inner_last ? '0 : r_inner + DIM_W'(1);
            if (w_inner_wrap) r_x     <= w_x_last     ? '0 : r_x + DIM_W'(1);
            if (w_x_wrap)     r_y     <= w_y_last     ? '0 : r_y + DIM_W'(1);
        end
    end

    assign o_count       = r_count;
    assign o_inner       = r_inner;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_first_inner = (r_inner == '0);
    assign o_last_inner  = w_inner_last;

endmodule

// File: rtl/ita_tile_sequencer.sv
// Issues operand beats over an (rows x cols x inner) problem tiled into M x M tiles,
// throttled by outstanding-result credits, with abort and a completion pulse.
module ita_tile_sequencer
    import ita_package::*;
#(
    parameter int unsigned M          = 64,
    parameter int unsigned N          = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIM_W      = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [DIM_W-1:0]              cfg_rows_i,
    input  logic [DIM_W-1:0]              cfg_cols_i,
    input  logic [DIM_W-1:0]              cfg_inner_i,
    input  logic                          inp_valid_i,
    output logic                          inp_ready_o,
    input  logic                          weight_valid_i,
    output logic                          weight_ready_o,
    input  logic                          oup_valid_i,
    input  logic                          oup_ready_i,
    output logic                          calc_en_o,
    output logic                          first_inner_o,
    output logic                          last_inner_o,
    output logic [DIM_W-1:0]              tile_x_o,
    output logic [DIM_W-1:0]              tile_y_o,
    output logic [DIM_W-1:0]              inner_tile_o,
    output logic [$clog2(M*M/N)-1:0]      count_o,
    output logic [N-1:0]                  lane_mask_o,
    output logic                          row_valid_o,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int unsigned BEATS = beat_count(M, N);
    localparam int unsigned XW    = DIM_W + 1;
    localparam int unsigned ONG_W = $clog2(FIFO_DEPTH + 1);

    state_e           r_state;
    logic [DIM_W-1:0] r_rows, r_cols, r_inner;
    logic [ONG_W-1:0] r_ongoing;
    logic             r_done;

    logic [XW-1:0] w_tiles_y, w_tiles_x, w_tiles_i;
    logic [XW-1:0] w_row, w_col_base;
    logic [$clog2(BEATS)-1:0] w_count;
    logic [DIM_W-1:0] w_tile_x, w_tile_y;
    logic w_run, w_stall, w_fire, w_clear, w_nest_wrap;
    logic w_inc, w_retire, w_zero_cfg, w_row_valid;

    assign w_tiles_y = XW'(ceil_div(32'(r_rows),  32'(M)));
    assign w_tiles_x = XW'(ceil_div(32'(r_cols),  32'(M)));
    assign w_tiles_i = XW'(ceil_div(32'(r_inner), 32'(M)));

    assign w_run    = (r_state == ST_RUN);
    assign w_stall  = (r_ongoing >= ONG_W'(FIFO_DEPTH));
    assign w_fire   = w_run & inp_valid_i & weight_valid_i & ~w_stall;
    assign w_clear  = abort_i | ((r_state == ST_IDLE) & start_i);
    assign w_inc    = w_fire & last_inner_o;
    assign w_retire = oup_valid_i & oup_ready_i;
    assign w_zero_cfg = (cfg_rows_i == '0) | (cfg_cols_i == '0) | (cfg_inner_i == '0);

    ita_tile_counter #(
        .BEATS (BEATS),
        .DIM_W (DIM_W)
    ) u_counter (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_clear       (w_clear),
        .i_en          (w_fire),
        .i_tiles_i     (w_tiles_i),
        .i_tiles_x     (w_tiles_x),
        .i_tiles_y     (w_tiles_y),
        .o_count       (w_count),
        .o_inner       (inner_tile_o),
        .o_x           (w_tile_x),
        .o_y           (w_tile_y),
        .o_first_inner (first_inner_o),
        .o_last_inner  (last_inner_o),
        .o_nest_wrap   (w_nest_wrap)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_rows    <= '0;
            r_cols    <= '0;
            r_inner   <= '0;
            r_ongoing <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort_i) begin
                r_state   <= ST_IDLE;
                r_ongoing <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: if (start_i) begin
                        r_rows  <= cfg_rows_i;
                        r_cols  <= cfg_cols_i;
                        r_inner <= cfg_inner_i;
                        r_state <= w_zero_cfg ? ST_DRAIN : ST_RUN;
                    end
                    ST_RUN: if (w_nest_wrap) r_state <= ST_DRAIN;
                    ST_DRAIN: if (r_ongoing == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
                // A retire with nothing outstanding is dropped; fire + retire cancel.
                if (w_inc && !w_retire)
                    r_ongoing <= r_ongoing + ONG_W'(1);
                else if (!w_inc && w_retire && (r_ongoing != '0))
                    r_ongoing <= r_ongoing - ONG_W'(1);
            end
        end
    end

    // Beats walk down the M rows first, then step N columns to the right.
    assign w_row      = XW'(32'(w_tile_y) * M + (32'(w_count) % M));
    assign w_col_base = XW'(32'(w_tile_x) * M + (32'(w_count) / M) * N);
    assign w_row_valid = (w_row < XW'(r_rows));

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign lane_mask_o[gi] = ((w_col_base + XW'(gi)) < XW'(r_cols)) & w_row_valid;
    end

    assign inp_ready_o    = w_run & weight_valid_i & ~w_stall;
    assign weight_ready_o = w_run & inp_valid_i & ~w_stall;
    assign calc_en_o      = w_fire;
    assign tile_x_o       = w_tile_x;
    assign tile_y_o       = w_tile_y;
    assign count_o        = w_count;
    assign row_valid_o    = w_row_valid;
    assign busy_o         = (r_state != ST_IDLE);
    assign done_o         = r_done;

endmodule

// File: tb/tb_ita_tile_sequencer.sv
// Directed bench for ita_tile_sequencer with M=4, N=2, FIFO_DEPTH=2.
module tb_ita_tile_sequencer;
    localparam int M  = 4;
    localparam int N  = 2;
    localparam int FD = 2;
    localparam int DW = 12;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic start_i = 1'b0, abort_i = 1'b0;
    logic [DW-1:0] cfg_rows_i = '0, cfg_cols_i = '0, cfg_inner_i = '0;
    logic inp_valid_i = 1'b0, weight_valid_i = 1'b0;
    logic oup_valid_i = 1'b0, oup_ready_i = 1'b0;
    logic inp_ready_o, weight_ready_o, calc_en_o, first_inner_o, last_inner_o;
    logic [DW-1:0] tile_x_o, tile_y_o, inner_tile_o;
    logic [$clog2(M*M/N)-1:0] count_o;
    logic [N-1:0] lane_mask_o;
    logic row_valid_o, busy_o, done_o;

    int n_pass = 0;
    int n_total = 0;

    logic s_fire, s_done, s_busy, s_inp_ready, s_wgt_ready, s_rv, s_last;
    logic [N-1:0] s_mask;
    int s_tx, s_ty, s_cnt;
    int rec_mask[64], rec_rv[64], rec_tx[64], rec_ty[64], rec_cnt[64];

    typedef struct {
        int rows;
        int cols;
        int inner;
        int fires;
        int ones;
        int lasts;
        int done_cyc;
    } vec_t;
    vec_t vecs[7];

    ita_tile_sequencer #(.M(M), .N(N), .FIFO_DEPTH(FD), .DIM_W(DW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .cfg_rows_i     (cfg_rows_i),
        .cfg_cols_i     (cfg_cols_i),
        .cfg_inner_i    (cfg_inner_i),
        .inp_valid_i    (inp_valid_i),
        .inp_ready_o    (inp_ready_o),
        .weight_valid_i (weight_valid_i),
        .weight_ready_o (weight_ready_o),
        .oup_valid_i    (oup_valid_i),
        .oup_ready_i    (oup_ready_i),
        .calc_en_o      (calc_en_o),
        .first_inner_o  (first_inner_o),
        .last_inner_o   (last_inner_o),
        .tile_x_o       (tile_x_o),
        .tile_y_o       (tile_y_o),
        .inner_tile_o   (inner_tile_o),
        .count_o        (count_o),
        .lane_mask_o    (lane_mask_o),
        .row_valid_o    (row_valid_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
            $display("check %s: got %0d expected %0d ok", name, act, exp);
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle's controls just after posedge, sample mid-cycle at negedge.
    task automatic do_cycle(input logic st, input logic ab, input logic ov, input logic orr);
        start_i = st;
        abort_i = ab;
        oup_valid_i = ov;
        oup_ready_i = orr;
        @(negedge clk_i);
        s_fire = calc_en_o;
        s_done = done_o;
        s_busy = busy_o;
        s_inp_ready = inp_ready_o;
        s_wgt_ready = weight_ready_o;
        s_mask = lane_mask_o;
        s_rv = row_valid_o;
        s_last = last_inner_o;
        s_tx = int'(tile_x_o);
        s_ty = int'(tile_y_o);
        s_cnt = int'(count_o);
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_vec(input int rows, input int cols, input int inner,
                           output int fires, output int ones, output int lasts, output int done_cyc);
        cfg_rows_i = DW'(rows);
        cfg_cols_i = DW'(cols);
        cfg_inner_i = DW'(inner);
        fires = 0;
        ones = 0;
        lasts = 0;
        done_cyc = -1;
        do_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        for (int c = 1; c <= 100; c++) begin
            do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
            if (s_fire) begin
                if (fires < 64) begin
                    rec_mask[fires] = int'(s_mask);
                    rec_rv[fires] = int'(s_rv);
                    rec_tx[fires] = s_tx;
                    rec_ty[fires] = s_ty;
                    rec_cnt[fires] = s_cnt;
                end
                fires++;
                ones += $countones(s_mask);
                lasts += int'(s_last);
            end
            if (s_done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    initial begin
        int fires, ones, lasts, done_cyc, f;
        bit seen_done;

        vecs[0] = '{rows: 4, cols: 4, inner: 4, fires: 8,  ones: 16, lasts: 8,  done_cyc: 10};
        vecs[1] = '{rows: 5, cols: 6, inner: 4, fires: 32, ones: 30, lasts: 32, done_cyc: 34};
        vecs[2] = '{rows: 4, cols: 4, inner: 8, fires: 16, ones: 32, lasts: 8,  done_cyc: 18};
        vecs[3] = '{rows: 3, cols: 2, inner: 1, fires: 8,  ones: 6,  lasts: 8,  done_cyc: 10};
        vecs[4] = '{rows: 8, cols: 1, inner: 5, fires: 32, ones: 16, lasts: 16, done_cyc: 34};
        vecs[5] = '{rows: 4, cols: 0, inner: 4, fires: 0,  ones: 0,  lasts: 0,  done_cyc: 2};
        vecs[6] = '{rows: 0, cols: 4, inner: 4, fires: 0,  ones: 0,  lasts: 0,  done_cyc: 2};

        // Reset state, with operands offered so ready/fire gating is exercised.
        inp_valid_i = 1'b1;
        weight_valid_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_calc_en", int'(calc_en_o), 0);
        chk("rst_inp_ready", int'(inp_ready_o), 0);
        chk("rst_weight_ready", int'(weight_ready_o), 0);
        chk("rst_lane_mask", int'(lane_mask_o), 0);
        chk("rst_count", int'(count_o), 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        for (int v = 0; v < 7; v++) begin
            run_vec(vecs[v].rows, vecs[v].cols, vecs[v].inner, fires, ones, lasts, done_cyc);
            chk($sformatf("v%0d_fires", v), fires, vecs[v].fires);
            chk($sformatf("v%0d_mask_ones", v), ones, vecs[v].ones);
            chk($sformatf("v%0d_last_inner_fires", v), lasts, vecs[v].lasts);
            chk($sformatf("v%0d_done_cycle", v), done_cyc, vecs[v].done_cyc);
            do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("v%0d_post_done_busy", v), int'(s_busy), 0);
            chk($sformatf("v%0d_done_one_cycle", v), int'(s_done), 0);
            if (v == 0) begin
                f = 0;
                for (int i = 0; i < 8; i++) f += (rec_mask[i] == 3) ? 1 : 0;
                chk("v0_mask_11_beats", f, 8);
            end
            if (v == 1) begin
                chk("v1_f8_tile_x", rec_tx[8], 1);
                chk("v1_f8_tile_y", rec_ty[8], 0);
                chk("v1_f24_tile_x", rec_tx[24], 1);
                chk("v1_f24_tile_y", rec_ty[24], 1);
                chk("v1_f24_count", rec_cnt[24], 0);
                chk("v1_f24_mask", rec_mask[24], 3);
                chk("v1_f24_row_valid", rec_rv[24], 1);
                chk("v1_f25_row_valid", rec_rv[25], 0);
                chk("v1_f25_mask", rec_mask[25], 0);
                chk("v1_f28_count", rec_cnt[28], 4);
                chk("v1_f28_mask", rec_mask[28], 0);
            end
        end

        // Credit stall: no retires, only FIFO_DEPTH beats may issue on the last inner tile.
        cfg_rows_i = DW'(4);
        cfg_cols_i = DW'(4);
        cfg_inner_i = DW'(4);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        f = 0;
        repeat (10) begin
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            f += int'(s_fire);
        end
        chk("stall_fires", f, 2);
        chk("stall_inp_ready", int'(s_inp_ready), 0);
        chk("stall_weight_ready", int'(s_wgt_ready), 0);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("retire_while_stalled_fire", int'(s_fire), 0);
        f = 0;
        repeat (5) begin
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            f += int'(s_fire);
        end
        chk("one_retire_one_fire", f, 1);

        // Fire and retire in the same cycle must leave the credit count alone.
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("fire_with_retire", int'(s_fire), 1);
        f = 0;
        repeat (4) begin
            do_cycle(1'b0, 1'b0, 1'b0, 1'b0);
            f += int'(s_fire);
        end
        chk("after_fire_retire_fires", f, 1);

        fires = 5;
        seen_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
            fires += int'(s_fire);
            if (s_done) begin
                seen_done = 1'b1;
                break;
            end
        end
        chk("credit_run_total_fires", fires, 8);
        chk("credit_run_done", int'(seen_done), 1);

        // Abort on the fifth beat, then a clean rerun.
        do_cycle(1'b1, 1'b0, 1'b1, 1'b1);
        f = 0;
        repeat (4) begin
            do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
            f += int'(s_fire);
        end
        chk("abort_prefires", f, 4);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b1);
        chk("abort_cycle_fire", int'(s_fire), 1);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
        chk("abort_busy", int'(s_busy), 0);
        chk("abort_calc_en", int'(s_fire), 0);
        chk("abort_count_cleared", s_cnt, 0);
        f = int'(s_done);
        repeat (10) begin
            do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
            f += int'(s_done);
        end
        chk("abort_no_done", f, 0);
        run_vec(4, 4, 4, fires, ones, lasts, done_cyc);
        chk("rerun_fires", fires, 8);
        chk("rerun_done_cycle", done_cyc, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
